// File: rtl/frame_draw_sequencer_if.sv
// Shared VGA write-port bundle between the draw clients and the sequencer.
// The sequencer is the master; clients and the adapter sit on the slave side.
interface frame_draw_sequencer_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [X_W-1:0] bk_x, bd_x, sp_x;
    logic [Y_W-1:0] bk_y, bd_y, sp_y;
    logic [2:0]     bk_col, bd_col, sp_col;
    logic           bk_plot, bd_plot, sp_plot;
    logic           bk_done, bd_done, sp_done;
    logic           bk_en, bd_en, sp_en;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;

    modport master (
        input  bk_x, bd_x, sp_x,
        input  bk_y, bd_y, sp_y,
        input  bk_col, bd_col, sp_col,
        input  bk_plot, bd_plot, sp_plot,
        input  bk_done, bd_done, sp_done,
        output bk_en, bd_en, sp_en,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output bk_x, bd_x, sp_x,
        output bk_y, bd_y, sp_y,
        output bk_col, bd_col, sp_col,
        output bk_plot, bd_plot, sp_plot,
        output bk_done, bd_done, sp_done,
        input  bk_en, bd_en, sp_en,
        input  vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Runs background, border and sprite engines in turn on each frame tick,
// muxing the active engine onto the single VGA write port.
module frame_draw_sequencer #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int TIMEOUT = 77000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [2:0] skip_mask,
    frame_draw_sequencer_if.master bus,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE, ARM_BK, RUN_BK, ARM_BD, RUN_BD, ARM_SP, RUN_SP, DONE
    } state_t;

    state_t          state, state_n;
    logic [2:0]      mask_q;
    logic [2:0]      en_q;
    logic            pending;
    logic [WD_W-1:0] wd;
    logic            wd_hit, abort, start, in_run, in_frame;

    // First unskipped phase at or after ph (0=bk, 1=bd, 2=sp).
    function automatic state_t arm_from(input logic [2:0] m,
                                        input logic [1:0] ph);
        if (ph == 2'd0 && !m[0]) return ARM_BK;
        if (ph <= 2'd1 && !m[1]) return ARM_BD;
        if (!m[2]) return ARM_SP;
        return DONE;
    endfunction

    assign wd_hit   = (wd == WD_W'(TIMEOUT - 1));
    assign in_run   = (state == RUN_BK) || (state == RUN_BD) ||
                      (state == RUN_SP);
    assign in_frame = (state != IDLE) && (state != DONE);
    assign start    = ((state == IDLE) && frame_tick) ||
                      ((state == DONE) && (pending || frame_tick));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            en_q        <= '0;
            mask_q      <= '0;
            pending     <= 1'b0;
            wd          <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_n;
            en_q[0] <= (state_n == ARM_BK) || (state_n == RUN_BK);
            en_q[1] <= (state_n == ARM_BD) || (state_n == RUN_BD);
            en_q[2] <= (state_n == ARM_SP) || (state_n == RUN_SP);
            if (start) mask_q <= skip_mask;
            if (state == DONE) pending <= 1'b0;
            else if (frame_tick && in_frame) pending <= 1'b1;
            if (frame_tick && in_frame && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            wd <= in_run ? wd + 1'b1 : '0;
            if (abort) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        unique case (state)
            IDLE:
                if (frame_tick) state_n = arm_from(skip_mask, 2'd0);
            ARM_BK: state_n = RUN_BK;
            ARM_BD: state_n = RUN_BD;
            ARM_SP: state_n = RUN_SP;
            RUN_BK:
                if (bus.bk_done) state_n = arm_from(mask_q, 2'd1);
                else if (wd_hit) begin
                    state_n = DONE;
                    abort   = 1'b1;
                end
            RUN_BD:
                if (bus.bd_done) state_n = arm_from(mask_q, 2'd2);
                else if (wd_hit) begin
                    state_n = DONE;
                    abort   = 1'b1;
                end
            RUN_SP:
                if (bus.sp_done) state_n = DONE;
                else if (wd_hit) begin
                    state_n = DONE;
                    abort   = 1'b1;
                end
            DONE:
                if (pending || frame_tick)
                    state_n = arm_from(skip_mask, 2'd0);
                else
                    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ARM cycles see stale client registers, so only RUN forwards pixels.
    always_comb begin
        busy           = (state != IDLE);
        frame_done     = (state == DONE);
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        unique case (state)
            RUN_BK: begin
                bus.vga_x      = bus.bk_x;
                bus.vga_y      = bus.bk_y;
                bus.vga_colour = bus.bk_col;
                bus.vga_plot   = bus.bk_plot;
            end
            RUN_BD: begin
                bus.vga_x      = bus.bd_x;
                bus.vga_y      = bus.bd_y;
                bus.vga_colour = bus.bd_col;
                bus.vga_plot   = bus.bd_plot;
            end
            RUN_SP: begin
                bus.vga_x      = bus.sp_x;
                bus.vga_y      = bus.sp_y;
                bus.vga_colour = bus.sp_col;
                bus.vga_plot   = bus.sp_plot;
            end
            default: ;
        endcase
    end

    assign bus.bk_en = en_q[0];
    assign bus.bd_en = en_q[1];
    assign bus.sp_en = en_q[2];
endmodule
